// File: rtl/tqvp_fpu_queue_ctrl.sv
// tqvp_fpu_queue_ctrl: TinyQV FPU front-end that issues to pipelined FP units
// and keeps up to DEPTH operations in flight or queued in an in-order FIFO.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ui_in              unused
//   uo_out             [0] result_avail, [1] busy, [7:2] zero
//   address, data_in   register byte address, write data
//   data_write_n       2'b11 = no write, any other value = write
//   data_read_n        2'b11 = no read, any other value = read
//   data_out           combinational read data for address
//   data_ready         always 1
//   user_interrupt     irq_en & result_avail
//   exec_valid         one-cycle issue strobe
//   exec_op/a/b        issued op (0 ADD, 1 SUB, 2 MUL) and operands
//   exec_done/result   in-order result return strobe and data
module tqvp_fpu_queue_ctrl #(
    parameter int FW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    ui_in,
    output logic [7:0]    uo_out,
    input  logic [5:0]    address,
    input  logic [31:0]   data_in,
    input  logic [1:0]    data_write_n,
    input  logic [1:0]    data_read_n,
    output logic [31:0]   data_out,
    output logic          data_ready,
    output logic          user_interrupt,
    output logic          exec_valid,
    output logic [1:0]    exec_op,
    output logic [FW-1:0] exec_a,
    output logic [FW-1:0] exec_b,
    input  logic          exec_done,
    input  logic [FW-1:0] exec_result
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] ADDR_OPA  = 6'h00;
    localparam logic [5:0] ADDR_OPB  = 6'h04;
    localparam logic [5:0] ADDR_CMD  = 6'h08;
    localparam logic [5:0] ADDR_RES  = 6'h0C;
    localparam logic [5:0] ADDR_STAT = 6'h10;
    localparam logic [5:0] ADDR_CTRL = 6'h14;

    localparam logic [5:0] DEPTH_U = 6'(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [FW-1:0] opa;
    logic [FW-1:0] opb;
    logic [2:0]    last_op;
    logic          irq_en;
    logic          ovf;
    logic          unf;
    logic          ill;
    logic [4:0]    outstanding;
    logic [4:0]    count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] mem [DEPTH];

    logic          wr;
    logic          rd;
    logic          wr_opa;
    logic          wr_opb;
    logic          wr_cmd;
    logic          wr_stat;
    logic          wr_ctrl;
    logic          rd_res;
    logic [2:0]    op;
    logic          op_ok;
    logic [5:0]    used;
    logic          credit;
    logic          issue;
    logic          flush;
    logic          done_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic          ovf_set;
    logic          unf_set;
    logic          ill_set;
    logic [FW-1:0] neg_b;
    logic          busy;
    logic          avail;

    // Bus bits that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{ui_in, data_in};

    assign wr      = data_write_n != 2'b11;
    assign rd      = data_read_n != 2'b11;
    assign wr_opa  = wr && address == ADDR_OPA;
    assign wr_opb  = wr && address == ADDR_OPB;
    assign wr_cmd  = wr && address == ADDR_CMD;
    assign wr_stat = wr && address == ADDR_STAT;
    assign wr_ctrl = wr && address == ADDR_CTRL;
    assign rd_res  = rd && address == ADDR_RES;

    assign op    = data_in[2:0];
    assign op_ok = op <= 3'd2;

    // Credit counts both in-flight and queued ops, so a result can never
    // arrive to a full FIFO. A pop in the same cycle does not add credit.
    assign used   = {1'b0, outstanding} + {1'b0, count};
    assign credit = used < DEPTH_U;
    assign issue  = wr_cmd && op_ok && credit;

    assign flush   = wr_ctrl && data_in[1];
    assign done_ok = exec_done && outstanding != 5'd0;

    assign fifo_full  = count == DEPTH_C;
    assign fifo_empty = count == 5'd0;

    // A flush frees every slot, so a result landing alongside it is kept.
    assign push = done_ok && (flush || !fifo_full);
    assign drop = done_ok && !flush && fifo_full;
    assign pop  = rd_res && !fifo_empty;

    assign ovf_set = (wr_cmd && op_ok && !credit) || drop;
    assign unf_set = rd_res && fifo_empty;
    assign ill_set = wr_cmd && !op_ok;

    assign neg_b = {~opb[FW-1], opb[FW-2:0]};

    assign busy  = outstanding != 5'd0;
    assign avail = !fifo_empty;

    assign uo_out         = {6'b0, busy, avail};
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_en && avail;

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_OPA:  data_out[FW-1:0] = opa;
            ADDR_OPB:  data_out[FW-1:0] = opb;
            ADDR_CMD:  data_out[2:0] = last_op;
            ADDR_RES: begin
                if (avail) data_out[FW-1:0] = mem[rd_ptr];
            end
            ADDR_STAT: data_out[20:0] = {
                outstanding, 3'b0, count, 2'b0,
                ill, unf, ovf, !credit, avail, busy
            };
            ADDR_CTRL: data_out[0] = irq_en;
            default:   data_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            last_op <= '0;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            ill     <= 1'b0;
        end else begin
            if (wr_opa) opa <= data_in[FW-1:0];
            if (wr_opb) opb <= data_in[FW-1:0];
            if (wr_cmd) last_op <= op;
            if (wr_ctrl) irq_en <= data_in[0];
            // New events win over a W1C in the same cycle.
            ovf <= (ovf && !(wr_stat && data_in[3])) || ovf_set;
            unf <= (unf && !(wr_stat && data_in[4])) || unf_set;
            ill <= (ill && !(wr_stat && data_in[5])) || ill_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_valid <= 1'b0;
            exec_op    <= '0;
            exec_a     <= '0;
            exec_b     <= '0;
        end else begin
            exec_valid <= issue;
            if (issue) begin
                exec_op <= op[1:0];
                exec_a  <= opa;
                exec_b  <= (op == 3'd1) ? neg_b : opb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (issue && !done_ok) begin
            outstanding <= outstanding + 5'd1;
        end else if (!issue && done_ok) begin
            outstanding <= outstanding - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? 5'd1 : 5'd0;
            if (push) mem[0] <= exec_result;
        end else begin
            if (push) begin
                mem[wr_ptr] <= exec_result;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + 5'd1;
            end else if (!push && pop) begin
                count <= count - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_tqvp_fpu_queue_ctrl.sv
// tb_tqvp_fpu_queue_ctrl: directed and random bench for the FPU queue front-end
// with a fixed-latency FP unit and a queue-based reference model.
module tb_tqvp_fpu_queue_ctrl;

    localparam int FW    = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    localparam logic [5:0] A_OPA  = 6'h00;
    localparam logic [5:0] A_OPB  = 6'h04;
    localparam logic [5:0] A_CMD  = 6'h08;
    localparam logic [5:0] A_RES  = 6'h0C;
    localparam logic [5:0] A_STAT = 6'h10;
    localparam logic [5:0] A_CTRL = 6'h14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    ui_in = 8'h00;
    logic [7:0]    uo_out;
    logic [5:0]    address = 6'h00;
    logic [31:0]   data_in = 32'h0;
    logic [1:0]    data_write_n = 2'b11;
    logic [1:0]    data_read_n = 2'b11;
    logic [31:0]   data_out;
    logic          data_ready;
    logic          user_interrupt;
    logic          exec_valid;
    logic [1:0]    exec_op;
    logic [FW-1:0] exec_a;
    logic [FW-1:0] exec_b;
    logic          exec_done = 1'b0;
    logic [FW-1:0] exec_result = '0;

    always #5 clk = ~clk;

    tqvp_fpu_queue_ctrl #(.FW(FW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt),
        .exec_valid     (exec_valid),
        .exec_op        (exec_op),
        .exec_a         (exec_a),
        .exec_b         (exec_b),
        .exec_done      (exec_done),
        .exec_result    (exec_result)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state.
    logic [15:0] m_fifo[$];
    int          m_out;
    bit          m_ovf, m_unf, m_ill, m_irq, m_valid;
    logic [15:0] m_opa, m_opb, m_ea, m_eb;
    logic [1:0]  m_eop;
    logic [2:0]  m_lastop;

    // Fixed-latency FP unit model; gate holds results back.
    int          pend_due[$];
    logic [15:0] pend_val[$];
    bit          gate = 1'b1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] res_fn(logic [1:0] op, logic [15:0] a,
                                           logic [15:0] b);
        if (op == 2'd0 && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        if (op == 2'd1 && a == 16'h4200 && b == 16'hBC00) return 16'h4000;
        return a ^ {b[7:0], b[15:8]} ^ {14'd0, op} ^ 16'h0101;
    endfunction

    function automatic logic [31:0] model_read(logic [5:0] a);
        int sz = m_fifo.size();
        int st;
        case (a)
            A_OPA:  return {16'd0, m_opa};
            A_OPB:  return {16'd0, m_opb};
            A_CMD:  return {29'd0, m_lastop};
            A_RES:  return (sz != 0) ? {16'd0, m_fifo[0]} : 32'd0;
            A_STAT: begin
                st = (m_out << 16) | (sz << 8) | (int'(m_ill) << 5)
                   | (int'(m_unf) << 4) | (int'(m_ovf) << 3)
                   | (int'(m_out + sz >= DEPTH) << 2)
                   | (int'(sz != 0) << 1) | int'(m_out != 0);
                return 32'(st);
            end
            A_CTRL: return {31'd0, m_irq};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_out = 0;
        m_ovf = 0; m_unf = 0; m_ill = 0; m_irq = 0; m_valid = 0;
        m_opa = 0; m_opb = 0; m_lastop = 0;
        m_ea = 0; m_eb = 0; m_eop = 0;
    endtask

    // Effect of the coming clock edge, from the inputs now applied.
    task automatic model_edge();
        bit wr = data_write_n != 2'b11;
        bit rd = data_read_n != 2'b11;
        int sz = m_fifo.size();
        bit done_ok = exec_done && m_out > 0;
        bit issue = 0;
        bit flush = 0;
        logic [2:0] op = data_in[2:0];
        if (wr) begin
            case (address)
                A_OPA: m_opa = data_in[15:0];
                A_OPB: m_opb = data_in[15:0];
                A_CMD: begin
                    m_lastop = op;
                    if (op > 3'd2) m_ill = 1;
                    else if (m_out + sz >= DEPTH) m_ovf = 1;
                    else begin
                        issue = 1;
                        m_ea  = m_opa;
                        m_eb  = (op == 3'd1) ? (m_opb ^ 16'h8000) : m_opb;
                        m_eop = op[1:0];
                    end
                end
                A_STAT: begin
                    if (data_in[3]) m_ovf = 0;
                    if (data_in[4]) m_unf = 0;
                    if (data_in[5]) m_ill = 0;
                end
                A_CTRL: begin
                    m_irq = data_in[0];
                    flush = data_in[1];
                end
                default: ;
            endcase
        end
        if (rd && address == A_RES) begin
            if (sz == 0) m_unf = 1;
            else if (!flush) void'(m_fifo.pop_front());
        end
        if (flush) m_fifo.delete();
        if (done_ok) begin
            if (flush || sz < DEPTH) m_fifo.push_back(exec_result);
            else m_ovf = 1;
        end
        m_out   = m_out + int'(issue) - int'(done_ok);
        m_valid = issue;
    endtask

    task automatic tick();
        if (rst_n) model_edge();
        else model_reset();
        @(posedge clk);
        #1;
        cyc++;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        chk("exec_valid", {31'd0, exec_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("exec_a", {16'd0, exec_a}, {16'd0, m_ea});
            chk("exec_b", {16'd0, exec_b}, {16'd0, m_eb});
            chk("exec_op", {30'd0, exec_op}, {30'd0, m_eop});
        end
        chk("uo_out", {24'd0, uo_out},
            {30'd0, m_out != 0, m_fifo.size() != 0});
        chk("irq", {31'd0, user_interrupt},
            {31'd0, m_irq && m_fifo.size() != 0});
        if (exec_valid) begin
            pend_due.push_back(cyc + LAT);
            pend_val.push_back(res_fn(exec_op, exec_a, exec_b));
        end
        if (gate && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            exec_done   = 1'b1;
            exec_result = pend_val.pop_front();
            void'(pend_due.pop_front());
        end else begin
            exec_done   = 1'b0;
            exec_result = 16'($urandom);
        end
    endtask

    task automatic bus_wr(logic [5:0] a, logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = 2'b00;
        tick();
    endtask

    task automatic bus_rd(logic [5:0] a, string tag, output logic [31:0] v);
        address     = a;
        data_read_n = 2'($urandom_range(0, 2));
        #1;
        v = data_out;
        chk(tag, data_out, model_read(a));
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && pend_due.size() > 0; i++) tick();
        tick();
        chk("drain_busy", {31'd0, uo_out[1]}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int r;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_uo", {24'd0, uo_out}, 32'd0);
        chk("rst_valid", {31'd0, exec_valid}, 32'd0);
        chk("rst_irq", {31'd0, user_interrupt}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd1);
        rst_n = 1'b1;
        bus_rd(A_STAT, "rst_stat", v);
        chk("rst_stat0", v, 32'd0);

        // ADD 1.0 + 2.0.
        bus_wr(A_OPA, 32'h3C00);
        bus_wr(A_OPB, 32'h4000);
        bus_wr(A_CMD, 32'd0);
        chk("add_valid", {31'd0, exec_valid}, 32'd1);
        chk("add_b", {16'd0, exec_b}, 32'h4000);
        drain();
        chk("add_avail", {31'd0, uo_out[0]}, 32'd1);
        bus_rd(A_RES, "add_res", v);
        chk("add_val", v, 32'h4200);
        bus_rd(A_STAT, "add_stat", v);
        chk("add_cnt", {27'd0, v[12:8]}, 32'd0);

        // SUB 3.0 - 1.0, sign of B inverted on issue.
        bus_wr(A_OPA, 32'h4200);
        bus_wr(A_OPB, 32'h3C00);
        bus_wr(A_CMD, 32'd1);
        chk("sub_b", {16'd0, exec_b}, 32'hBC00);
        drain();
        bus_rd(A_RES, "sub_res", v);
        chk("sub_val", v, 32'h4000);

        // Five MULs against DEPTH credits.
        for (int i = 0; i < 5; i++) begin
            bus_wr(A_OPA, $urandom);
            bus_wr(A_OPB, $urandom);
            bus_wr(A_CMD, 32'd2);
        end
        bus_rd(A_STAT, "mul_stat", v);
        chk("mul_ovf", {31'd0, v[3]}, 32'd1);
        chk("mul_full", {31'd0, v[2]}, 32'd1);
        drain();
        for (int i = 0; i < 4; i++) bus_rd(A_RES, "mul_res", v);
        bus_rd(A_RES, "empty_res", v);
        chk("empty_val", v, 32'd0);
        bus_rd(A_STAT, "unf_stat", v);
        chk("unf_bit", {31'd0, v[4]}, 32'd1);
        bus_wr(A_STAT, 32'h38);
        bus_rd(A_STAT, "w1c_stat", v);
        chk("w1c_bits", {29'd0, v[5:3]}, 32'd0);

        // Illegal op.
        bus_wr(A_CMD, 32'd5);
        chk("ill_valid", {31'd0, exec_valid}, 32'd0);
        bus_rd(A_STAT, "ill_stat", v);
        chk("ill_bit", {31'd0, v[5]}, 32'd1);
        bus_rd(A_CMD, "ill_cmd", v);
        chk("ill_cmd_val", v, 32'd5);

        // Interrupt timing and simultaneous push/pop.
        bus_wr(A_CTRL, 32'd1);
        bus_wr(A_OPA, $urandom);
        bus_wr(A_OPB, $urandom);
        bus_wr(A_CMD, 32'd0);
        for (int i = 0; i < 20 && !exec_done; i++) tick();
        chk("irq_pre", {31'd0, user_interrupt}, 32'd0);
        tick();
        chk("irq_rise", {31'd0, user_interrupt}, 32'd1);
        gate = 1'b0;
        bus_wr(A_CMD, 32'd2);
        repeat (5) tick();
        gate = 1'b1;
        tick();
        bus_rd(A_RES, "pp_res", v);
        bus_rd(A_STAT, "pp_stat", v);
        chk("pp_cnt", {27'd0, v[12:8]}, 32'd1);
        bus_rd(A_RES, "pp_head", v);
        chk("irq_fall", {31'd0, user_interrupt}, 32'd0);

        // Flush with two queued and one in flight.
        bus_wr(A_CMD, 32'd0);
        bus_wr(A_CMD, 32'd1);
        drain();
        gate = 1'b0;
        bus_wr(A_CMD, 32'd2);
        repeat (5) tick();
        bus_wr(A_CTRL, 32'd3);
        bus_rd(A_STAT, "fl_stat", v);
        chk("fl_cnt", {27'd0, v[12:8]}, 32'd0);
        chk("fl_busy", {31'd0, v[0]}, 32'd1);
        gate = 1'b1;
        drain();
        bus_rd(A_STAT, "fl_land", v);
        chk("fl_land_cnt", {27'd0, v[12:8]}, 32'd1);
        // Flush and a landing result in the same cycle.
        gate = 1'b0;
        bus_wr(A_CMD, 32'd0);
        repeat (5) tick();
        gate = 1'b1;
        tick();
        bus_wr(A_CTRL, 32'd3);
        bus_rd(A_STAT, "fd_stat", v);
        chk("fd_cnt", {27'd0, v[12:8]}, 32'd1);
        bus_rd(A_RES, "fd_res", v);

        // Reset while busy, then a stray result.
        gate = 1'b0;
        bus_wr(A_CMD, 32'd2);
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_uo", {24'd0, uo_out}, 32'd0);
        chk("mid_valid", {31'd0, exec_valid}, 32'd0);
        chk("mid_irq", {31'd0, user_interrupt}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        gate = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus_rd(A_STAT, "stray_stat", v);
        chk("stray_zero", v, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            gate = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 11);
            case (r)
                0: bus_wr(A_OPA, $urandom);
                1: bus_wr(A_OPB, $urandom);
                2, 3, 4: bus_wr(A_CMD,
                    ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 3)));
                5, 6: bus_rd(A_RES, "rnd_res", v);
                7: bus_rd(6'($urandom_range(0, 6) * 4), "rnd_rd", v);
                8: bus_wr(A_STAT, $urandom & 32'h38);
                9: bus_wr(A_CTRL, ($urandom_range(0, 7) == 0) ? 32'd3 : 32'd1);
                default: tick();
            endcase
        end
        gate = 1'b1;
        drain();
        for (int i = 0; i < DEPTH + 1; i++) bus_rd(A_RES, "end_res", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tqvp_fpu_queue_ctrl.md
Name: tqvp_fpu_queue_ctrl

Overview:
- Parametrised TinyQV peripheral front-end for floating-point arithmetic, successor to the single-shot FPU peripheral.
- Accepts operands and commands over the peripheral bus and issues them to external pipelined FP units through an exec port.
- Allows up to DEPTH operations in flight, queues their results in an in-order result FIFO, and reports sticky error flags and an interrupt.

Parameters:
FW, 16, floating-point operand/result width (16 = FP16/bf16, 32 = FP32).
DEPTH, 4, result FIFO depth; this is also the maximum of (in-flight + queued) operations, power of 2, range 2..16.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ui_in  in  8  unused
uo_out  out  8  [0] result_avail, [1] busy, [7:2] 0
address  in  6  register byte address
data_in  in  32  write data
data_write_n  in  2  11 = no write; any other value = write
data_read_n  in  2  11 = no read; any other value = read
data_out  out  32  read data, combinational from address
data_ready  out  1  tied 1 (all reads are single-cycle)
user_interrupt  out  1  irq_en AND result_avail
exec_valid  out  1  one-cycle issue strobe to the FP units
exec_op  out  2  0 ADD, 1 SUB, 2 MUL
exec_a  out  FW  operand A
exec_b  out  FW  operand B; sign already inverted for SUB
exec_done  in  1  result strobe; results return in issue order
exec_result  in  FW  result, valid while exec_done = 1

Behaviour:
- Register map (bits above FW read as 0):
  - 0x00 OPA: R/W.
  - 0x04 OPB: R/W.
  - 0x08 CMD: write [2:0] = op, which issues the op; read returns the last op.
  - 0x0C RESULT: read returns the FIFO head zero-extended and pops it; returns 0 when empty.
  - 0x10 STATUS: read-only except W1C on [5:3].
    - [0] busy (outstanding != 0), [1] result_avail (count != 0), [2] full (no credit).
    - [3] overflow, [4] underflow, [5] illegal_op (all sticky).
    - [12:8] count, [20:16] outstanding.
  - 0x14 CTRL: [0] irq_en, [1] flush (self-clearing, always reads 0).
- Reset: every register, counter, FIFO pointer and flag is 0; exec_valid = 0; uo_out = 0; user_interrupt = 0.
- Credit rule: a CMD write issues only if op <= 2 and (outstanding + count) < DEPTH. Both values are sampled in the same cycle as the write; a pop in that cycle does not add credit.
- Rejected CMD writes:
  - op > 2 sets illegal_op.
  - No credit sets overflow.
  - In both cases there is no issue, OPA/OPB are unchanged, and CMD still records the op.
- Issue: when a CMD write is accepted at cycle T, exec_valid = 1 at T+1 only. exec_a/exec_b/exec_op are registered copies of OPA/OPB/op taken at T, and are held until the next issue.
- outstanding counter:
  - +1 on issue, -1 on exec_done.
  - Both in the same cycle: unchanged.
  - exec_done with outstanding == 0 is ignored; it does not push.
- Result FIFO:
  - exec_done at cycle D pushes exec_result; count and result_avail update at D+1.
  - A RESULT read pops at the same edge that data_out is sampled.
  - Push and pop in the same cycle: count unchanged; head data is the pre-pop head.
  - Pointers wrap modulo DEPTH.
  - Pop when empty: returns 0 and sets underflow; the pointers do not move.
  - Push when full is impossible by the credit rule. If it does occur, it is dropped and overflow is set.
- Flush: empties the FIFO (count = 0, pointers = 0) on the next edge. outstanding is kept; ops still in flight land normally afterwards. A flush and an exec_done in the same cycle: the flush wins for existing entries and the new result is still pushed.
- Writes to OPA/OPB are accepted at any time, including while busy; in-flight ops are unaffected.
- Reset mid-operation clears everything immediately. A later exec_done arrives with outstanding == 0 and is ignored.
- Reads with side effects happen only when data_read_n != 11. A read of STATUS has no side effect.

Test Plan:
- FW=16. Write OPA=0x3C00, OPB=0x4000, CMD=0; bench unit latency 3 -> exec_valid exactly 1 cycle after the CMD write, with exec_b=0x4000. Then result_avail=1, RESULT reads 0x4200, and count returns to 0.
- SUB with OPA=0x4200, OPB=0x3C00 -> exec_b=0xBC00; bench returns 0x4000; RESULT reads 0x4000.
- DEPTH=4: issue 5 back-to-back MULs without reading -> 4 issued, 5th rejected, STATUS.overflow=1, full=1. Four RESULT reads return the values in issue order. A 5th read returns 0 and sets underflow. Writing 0x38 to STATUS clears all sticky flags.
- CMD=5 -> no exec_valid, illegal_op=1.
- irq_en=1 -> user_interrupt rises the cycle after the first push and falls the cycle after the last pop. Push and pop in the same cycle with count=1 -> count stays 1 and the head advances.
- With 2 results queued and 1 in flight: write CTRL.flush -> count=0 next cycle, the in-flight result then lands with count=1. Assert rst_n low while busy -> all outputs 0 immediately; a subsequent stray exec_done is ignored.
